// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit CPU pipeline: opcodes,
// instruction fields, per-opcode operand usage and stage bundles.
package cpu_pkg;

    localparam int DW = 16;
    localparam int AW = 4;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_ADDI = 4'd6,
        OP_SLLI = 4'd7,
        OP_LW   = 4'd8,
        OP_SW   = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_ANDI = 4'd12,
        OP_ORI  = 4'd13,
        OP_JR   = 4'd14,
        OP_NOP  = 4'd15
    } op_e;

    // [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4
    typedef struct packed {
        op_e           op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
    } instr_t;

    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    typedef struct packed {
        logic          valid;
        op_e           op;
        logic [AW-1:0] rd;
        logic          wen;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
    } id_ex_t;

    // One bit per opcode
    localparam logic [15:0] USES_RS_TBL   = 16'h7FFF;
    localparam logic [15:0] USES_RT_TBL   = 16'h0E3F;
    localparam logic [15:0] WRITES_RD_TBL = 16'h31FF;

    function automatic logic uses_rs(input op_e op);
        return USES_RS_TBL[op];
    endfunction

    function automatic logic uses_rt(input op_e op);
        return USES_RT_TBL[op];
    endfunction

    function automatic logic writes_rd(input op_e op);
        return WRITES_RD_TBL[op];
    endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Per-operand bypass select: R0, EX result, WB write, delayed WB
// write, then register file data, in that priority.
module operand_forward_mux
    import cpu_pkg::*;
(
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] rdata_i,
    input  wb_t           ex_i,
    input  wb_t           wb_i,
    input  wb_t           wbd_i,
    output logic [DW-1:0] data_o
);

    always_comb begin
        data_o = rdata_i;
        if (addr_i == '0) begin
            data_o = '0;
        end else if (ex_i.wen && ex_i.addr == addr_i) begin
            data_o = ex_i.data;
        end else if (wb_i.wen && wb_i.addr == addr_i) begin
            data_o = wb_i.data;
        end else if (wbd_i.wen && wbd_i.addr == addr_i) begin
            data_o = wbd_i.data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: register read, bypass, load-use
// stall and the ID/EX pipeline register.
module operand_fetch_stage
    import cpu_pkg::*;
(
    input  logic          Clock,
    input  logic          Reset,
    input  logic          In_Valid,
    input  logic [DW-1:0] In_Instr,
    input  logic [DW-1:0] In_PC,
    output logic          In_Ready,
    input  logic          Flush,
    output logic [AW-1:0] RAddr1,
    output logic [AW-1:0] RAddr2,
    input  logic [DW-1:0] RData1,
    input  logic [DW-1:0] RData2,
    input  logic          Ex_Wen,
    input  logic          Ex_IsLoad,
    input  logic [AW-1:0] Ex_WAddr,
    input  logic [DW-1:0] Ex_Result,
    input  logic          Wb_Wen,
    input  logic [AW-1:0] Wb_WAddr,
    input  logic [DW-1:0] Wb_WData,
    output logic          Out_Valid,
    output logic [3:0]    Out_Op,
    output logic [AW-1:0] Out_Rd,
    output logic          Out_Wen,
    output logic [DW-1:0] Out_A,
    output logic [DW-1:0] Out_B,
    output logic [DW-1:0] Out_Imm,
    output logic [DW-1:0] Out_PC
);

    instr_t        in_instr;
    instr_t        s1_instr_q;
    logic [DW-1:0] s1_pc_q;
    logic          s1_valid_q, s1_valid_d;
    wb_t           wbd_q;
    wb_t           ex_fw, wb_now;
    id_ex_t        id_ex_q;
    logic          hazard, stall, accept, advance;
    logic [DW-1:0] fwd_a, fwd_b;

    assign in_instr = instr_t'(In_Instr);

    assign hazard = Ex_Wen && Ex_IsLoad && (Ex_WAddr != '0)
        && ((uses_rs(s1_instr_q.op) && s1_instr_q.rs == Ex_WAddr)
         || (uses_rt(s1_instr_q.op) && s1_instr_q.rt == Ex_WAddr));

    assign stall      = s1_valid_q && hazard && !Flush;
    assign In_Ready   = !stall;
    assign accept     = In_Valid && In_Ready && !Flush;
    assign advance    = s1_valid_q && !stall && !Flush;
    assign s1_valid_d = stall || accept;

    // Re-issue the held reads so fresh data arrives after the stall
    assign RAddr1 = stall ? s1_instr_q.rs : in_instr.rs;
    assign RAddr2 = stall ? s1_instr_q.rt : in_instr.rt;

    always_comb begin
        ex_fw      = '0;
        ex_fw.wen  = Ex_Wen && !Ex_IsLoad;
        ex_fw.addr = Ex_WAddr;
        ex_fw.data = Ex_Result;
        wb_now      = '0;
        wb_now.wen  = Wb_Wen;
        wb_now.addr = Wb_WAddr;
        wb_now.data = Wb_WData;
    end

    operand_forward_mux u_fwd_a (
        .addr_i  (s1_instr_q.rs),
        .rdata_i (RData1),
        .ex_i    (ex_fw),
        .wb_i    (wb_now),
        .wbd_i   (wbd_q),
        .data_o  (fwd_a)
    );

    operand_forward_mux u_fwd_b (
        .addr_i  (s1_instr_q.rt),
        .rdata_i (RData2),
        .ex_i    (ex_fw),
        .wb_i    (wb_now),
        .wbd_i   (wbd_q),
        .data_o  (fwd_b)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_pc_q    <= '0;
            wbd_q      <= '0;
            id_ex_q    <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            wbd_q         <= wb_now;
            id_ex_q.valid <= advance;
            if (accept) begin
                s1_instr_q <= in_instr;
                s1_pc_q    <= In_PC;
            end
            if (advance) begin
                id_ex_q.op  <= s1_instr_q.op;
                id_ex_q.rd  <= s1_instr_q.rd;
                id_ex_q.wen <= writes_rd(s1_instr_q.op);
                id_ex_q.a   <= fwd_a;
                id_ex_q.b   <= fwd_b;
                id_ex_q.imm <= {{(DW-AW){s1_instr_q.rt[AW-1]}},
                                s1_instr_q.rt};
                id_ex_q.pc  <= s1_pc_q;
            end
        end
    end

    assign Out_Valid = id_ex_q.valid;
    assign Out_Op    = id_ex_q.op;
    assign Out_Rd    = id_ex_q.rd;
    assign Out_Wen   = id_ex_q.wen;
    assign Out_A     = id_ex_q.a;
    assign Out_B     = id_ex_q.b;
    assign Out_Imm   = id_ex_q.imm;
    assign Out_PC    = id_ex_q.pc;

endmodule
